// File: rtl/hdmi_pixel_packer.sv
// Packs PIXEL_BYTES pixels MSB-first into WORD_BYTES FIFO words framed on vSync; define HDMI_PACKER_FLUSH_EN to flush partial words at frame end.
// Word registered 1 cycle after its completing pixel; no backpressure: words offered while i_fifoFull is high are lost and counted.
module hdmi_pixel_packer #(
  parameter int PIXEL_BYTES  = 3,
  parameter int WORD_BYTES   = 4,
  parameter int VSYNC_ACT_HI = 1,
  parameter int DROP_CNT_W   = 16
) (
  input  logic                     i_hdmiClock,
  input  logic                     i_nReset,
  input  logic [PIXEL_BYTES*8-1:0] i_hdmiData,
  input  logic                     i_hdmiEnable,
  input  logic                     i_hSync,
  input  logic                     i_vSync,
  input  logic                     i_fifoFull,
  output logic                     o_dataValid,
  output logic [WORD_BYTES*8-1:0]  o_fifoData,
  output logic                     o_firstWord,
  output logic                     o_overflow,
  output logic [DROP_CNT_W-1:0]    o_dropCount
);

  localparam int BUF_BYTES = WORD_BYTES + PIXEL_BYTES;
  localparam int BUF_W     = BUF_BYTES * 8;
  localparam int WORD_W    = WORD_BYTES * 8;
  localparam int PIXEL_W   = PIXEL_BYTES * 8;
  localparam int CNT_W     = $clog2(BUF_BYTES);

  typedef enum logic {UNSYNC, ACTIVE} state_t;

  state_t             state, stateNxt;
  logic [BUF_W-1:0]   byteBuf, byteBufNxt;
  logic [CNT_W-1:0]   byteCnt, byteCntNxt;
  logic               firstArmed, firstArmedNxt;
  logic               vSyncReg, vSyncPrev;
  logic               vSyncAct;
  logic               boundary;
  logic               emitVld;
  logic [WORD_W-1:0]  emitDat;
  logic               emitFirst;
  logic [BUF_W-1:0]   pixelExt;
  logic [BUF_W-1:0]   merged;
  int                 appendShift;
  int                 fill;
  logic               unusedHSync;

  assign unusedHSync = i_hSync;
  assign vSyncAct    = (VSYNC_ACT_HI != 0) ? i_vSync : ~i_vSync;
  assign boundary    = vSyncReg & ~vSyncPrev;
  assign pixelExt    = {{WORD_W{1'b0}}, i_hdmiData};

  // Residual lives in the top byteCnt bytes of byteBuf; everything below it is kept zero.
  always_comb begin
    stateNxt      = state;
    byteBufNxt    = byteBuf;
    byteCntNxt    = byteCnt;
    firstArmedNxt = firstArmed;
    emitVld       = 1'b0;
    emitDat       = '0;
    emitFirst     = 1'b0;
    appendShift   = (WORD_BYTES - int'(byteCnt)) * 8;
    fill          = int'(byteCnt) + PIXEL_BYTES;
    merged        = byteBuf | (pixelExt << appendShift);

    case (state)
      UNSYNC: begin
        if (boundary) begin
          stateNxt      = ACTIVE;
          byteBufNxt    = '0;
          byteCntNxt    = '0;
          firstArmedNxt = 1'b1;
        end
      end
      ACTIVE: begin
        if (boundary) begin
`ifdef HDMI_PACKER_FLUSH_EN
          if (byteCnt != '0) begin
            emitVld   = 1'b1;
            emitDat   = byteBuf[BUF_W-1 -: WORD_W];
            emitFirst = 1'b0;
          end
`endif
          byteBufNxt    = '0;
          byteCntNxt    = '0;
          firstArmedNxt = 1'b1;
        end else if (i_hdmiEnable) begin
          if (fill >= WORD_BYTES) begin
            emitVld       = 1'b1;
            emitDat       = merged[BUF_W-1 -: WORD_W];
            emitFirst     = firstArmed;
            firstArmedNxt = 1'b0;
            byteBufNxt    = merged << WORD_W;
            byteCntNxt    = CNT_W'(fill - WORD_BYTES);
          end else begin
            byteBufNxt = merged;
            byteCntNxt = CNT_W'(fill);
          end
        end
      end
      default: stateNxt = UNSYNC;
    endcase
  end

  always_ff @(posedge i_hdmiClock or negedge i_nReset) begin
    if (!i_nReset) begin
      state       <= UNSYNC;
      byteBuf     <= '0;
      byteCnt     <= '0;
      firstArmed  <= 1'b0;
      vSyncReg    <= 1'b0;
      vSyncPrev   <= 1'b0;
      o_dataValid <= 1'b0;
      o_fifoData  <= '0;
      o_firstWord <= 1'b0;
      o_overflow  <= 1'b0;
      o_dropCount <= '0;
    end else begin
      state       <= stateNxt;
      byteBuf     <= byteBufNxt;
      byteCnt     <= byteCntNxt;
      firstArmed  <= firstArmedNxt;
      vSyncReg    <= vSyncAct;
      vSyncPrev   <= vSyncReg;
      o_dataValid <= emitVld;
      o_firstWord <= emitVld & emitFirst;
      if (emitVld) begin
        o_fifoData <= emitDat;
      end
      // The word currently on the output is the one the FIFO refuses.
      if (o_dataValid && i_fifoFull) begin
        o_overflow <= 1'b1;
        if (o_dropCount != '1) begin
          o_dropCount <= o_dropCount + DROP_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hdmi_pixel_packer.sv
// Bench for hdmi_pixel_packer: vector table, corner-case sequences and a byte-queue reference model.
module tb_hdmi_pixel_packer;

  logic clk;
  logic nReset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration
  logic [23:0] aData;
  logic        aEn, aHs, aVs, aFull;
  logic        aVld, aFirst, aOvf;
  logic [31:0] aWord;
  logic [15:0] aDrop;

  // 2-byte pixels into 4-byte words
  logic [15:0] bData;
  logic        bEn, bHs, bVs, bFull;
  logic        bVld, bFirst, bOvf;
  logic [31:0] bWord;
  logic [15:0] bDrop;

  // 4-byte pixels, active-low vSync, narrow drop counter
  logic [31:0] cData;
  logic        cEn, cHs, cVs, cFull;
  logic        cVld, cFirst, cOvf;
  logic [31:0] cWord;
  logic [7:0]  cDrop;

  hdmi_pixel_packer dutA (
    .i_hdmiClock(clk), .i_nReset(nReset), .i_hdmiData(aData), .i_hdmiEnable(aEn),
    .i_hSync(aHs), .i_vSync(aVs), .i_fifoFull(aFull), .o_dataValid(aVld),
    .o_fifoData(aWord), .o_firstWord(aFirst), .o_overflow(aOvf), .o_dropCount(aDrop));

  hdmi_pixel_packer #(.PIXEL_BYTES(2), .WORD_BYTES(4)) dutB (
    .i_hdmiClock(clk), .i_nReset(nReset), .i_hdmiData(bData), .i_hdmiEnable(bEn),
    .i_hSync(bHs), .i_vSync(bVs), .i_fifoFull(bFull), .o_dataValid(bVld),
    .o_fifoData(bWord), .o_firstWord(bFirst), .o_overflow(bOvf), .o_dropCount(bDrop));

  hdmi_pixel_packer #(.PIXEL_BYTES(4), .WORD_BYTES(4), .VSYNC_ACT_HI(0), .DROP_CNT_W(8)) dutC (
    .i_hdmiClock(clk), .i_nReset(nReset), .i_hdmiData(cData), .i_hdmiEnable(cEn),
    .i_hSync(cHs), .i_vSync(cVs), .i_fifoFull(cFull), .o_dataValid(cVld),
    .o_fifoData(cWord), .o_firstWord(cFirst), .o_overflow(cOvf), .o_dropCount(cDrop));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        vs;
    logic        en;
    logic [23:0] dat;
    logic        full;
    logic        expVld;
    logic [31:0] expWord;
    logic        expFirst;
    logic        expOvf;
    logic [15:0] expDrop;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] tWord;
  logic        tOvf;
  logic [15:0] tDrop;

  task automatic addRow(input logic vs, input logic en, input logic [23:0] dat, input logic full,
                        input logic vld, input logic [31:0] word, input logic first);
    vec_t v;
    if (vld) tWord = word;
    v.vs = vs; v.en = en; v.dat = dat; v.full = full;
    v.expVld = vld; v.expWord = tWord; v.expFirst = first;
    v.expOvf = tOvf; v.expDrop = tDrop;
    vecs.push_back(v);
  endtask

  task automatic addPx(input logic [23:0] dat, input logic full, input logic vld,
                       input logic [31:0] word, input logic first);
    addRow(1'b0, 1'b1, dat, full, vld, word, first);
  endtask

  task automatic addIdle();
    addRow(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic addSync();
    addRow(1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    addRow(1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    addIdle();
    addIdle();
  endtask

  task automatic pulseSyncA();
    aVs = 1'b1;
    repeat (2) @(negedge clk);
    aVs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Reference model state
  logic [7:0]  q[$];
  logic [32:0] expQ[$];
  logic [32:0] e;
  logic [31:0] mw;
  bit          synced, armed, vldSeen;
  int          expDrops, vsHold, blockLeft, nv;
  logic [31:0] fw;
  logic        ff;

  initial begin
    nReset = 1'b0;
    aData = '0; aEn = 0; aHs = 0; aVs = 0; aFull = 0;
    bData = '0; bEn = 0; bHs = 0; bVs = 0; bFull = 0;
    cData = '0; cEn = 0; cHs = 0; cVs = 1; cFull = 0;
    repeat (2) @(negedge clk);
    check("rst_vld", aVld, 0);
    check("rst_word", aWord, 0);
    check("rst_first", aFirst, 0);
    check("rst_ovf", aOvf, 0);
    check("rst_drop", aDrop, 0);
    nReset = 1'b1;
    @(negedge clk);

    // Vector table: unsynced pixels, three frames (plain, one drop, enable gap)
    tWord = 0; tOvf = 0; tDrop = 0;
    addPx(24'hDEAD01, 0, 0, 0, 0); addPx(24'hDEAD02, 0, 0, 0, 0);
    addPx(24'hDEAD03, 0, 0, 0, 0); addPx(24'hDEAD04, 0, 0, 0, 0);
    addSync();
    addPx(24'h112233, 0, 0, 32'h0, 0);
    addPx(24'h445566, 0, 1, 32'h11223344, 1);
    addPx(24'h778899, 0, 1, 32'h55667788, 0);
    addPx(24'hAABBCC, 0, 1, 32'h99AABBCC, 0);
    addIdle();
    addSync();
    addPx(24'h112233, 0, 0, 32'h0, 0);
    addPx(24'h445566, 0, 1, 32'h11223344, 1);
    addPx(24'h778899, 0, 1, 32'h55667788, 0);
    tOvf = 1; tDrop = 1;
    addPx(24'hAABBCC, 1, 1, 32'h99AABBCC, 0);
    addIdle();
    addSync();
    addPx(24'h112233, 0, 0, 32'h0, 0);
    addPx(24'h445566, 0, 1, 32'h11223344, 1);
    repeat (10) addIdle();
    addPx(24'h778899, 0, 1, 32'h55667788, 0);
    addPx(24'hAABBCC, 0, 1, 32'h99AABBCC, 0);
    addIdle();

    for (int i = 0; i < vecs.size(); i++) begin
      aVs = vecs[i].vs; aEn = vecs[i].en; aData = vecs[i].dat; aFull = vecs[i].full;
      @(negedge clk);
      check($sformatf("vec%0d_vld", i), aVld, vecs[i].expVld);
      check($sformatf("vec%0d_word", i), aWord, vecs[i].expWord);
      check($sformatf("vec%0d_first", i), aFirst, vecs[i].expFirst);
      check($sformatf("vec%0d_ovf", i), aOvf, vecs[i].expOvf);
      check($sformatf("vec%0d_drop", i), aDrop, vecs[i].expDrop);
    end
    aEn = 0; aFull = 0;

    // Partial word at frame end
    pulseSyncA();
    aEn = 1; aData = 24'h112233; @(negedge clk);
    aData = 24'h445566; @(negedge clk);
    check("flush_w1_vld", aVld, 1);
    check("flush_w1_word", aWord, 32'h11223344);
    aEn = 0;
    aVs = 1'b1;
    nv = 0; fw = 0; ff = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) aVs = 1'b0;
      @(negedge clk);
      if (aVld) begin nv++; fw = aWord; ff = aFirst; end
    end
`ifdef HDMI_PACKER_FLUSH_EN
    check("flush_count", nv, 1);
    check("flush_word", fw, 32'h55660000);
    check("flush_first", ff, 0);
`else
    check("flush_none", nv, 0);
`endif
    aEn = 1; aData = 24'hA1A2A3; @(negedge clk);
    aData = 24'hB1B2B3; @(negedge clk);
    check("clean_vld", aVld, 1);
    check("clean_word", aWord, 32'hA1A2A3B1);
    check("clean_first", aFirst, 1);

    // Reset mid-word, then pixels without a vSync edge
    aData = 24'h123456; @(negedge clk);
    aEn = 0;
    nReset = 1'b0;
    #1;
    check("midrst_vld", aVld, 0);
    check("midrst_word", aWord, 0);
    check("midrst_first", aFirst, 0);
    check("midrst_ovf", aOvf, 0);
    check("midrst_drop", aDrop, 0);
    @(negedge clk);
    nReset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      aEn = 1; aData = 24'h010203 * (k + 1);
      @(negedge clk);
      check($sformatf("unsync%0d_vld", k), aVld, 0);
    end
    aEn = 0;

    // 2-byte pixel configuration
    bVs = 1; repeat (2) @(negedge clk);
    bVs = 0; repeat (2) @(negedge clk);
    bEn = 1; bData = 16'h1122; @(negedge clk);
    check("p2_w_none", bVld, 0);
    bData = 16'h3344; @(negedge clk);
    check("p2_vld", bVld, 1);
    check("p2_word", bWord, 32'h11223344);
    check("p2_first", bFirst, 1);
    bEn = 0; @(negedge clk);
    check("p2_vld_end", bVld, 0);
    check("p2_drop", bDrop, 0);
    check("p2_ovf", bOvf, 0);

    // Drop counter saturation with active-low vSync, one word per cycle
    cVs = 0; repeat (2) @(negedge clk);
    cVs = 1; repeat (2) @(negedge clk);
    cEn = 1; cFull = 1; cData = 32'hC0DE0000;
    @(negedge clk);
    check("sat_first_vld", cVld, 1);
    check("sat_first_word", cWord, 32'hC0DE0000);
    check("sat_first_first", cFirst, 1);
    for (int k = 1; k < 270; k++) begin
      cData = 32'hC0DE0000 + k;
      @(negedge clk);
    end
    cEn = 0;
    repeat (2) @(negedge clk);
    check("sat_drop", cDrop, 8'hFF);
    check("sat_ovf", cOvf, 1);
    check("sat_word_held", cWord, 32'hC0DE0000 + 269);
    cFull = 0;

    // Randomized run against the byte-queue model
    nReset = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
    q.delete(); expQ.delete();
    synced = 0; armed = 0; expDrops = 0; vsHold = 0; blockLeft = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rand_drop", aDrop, 16'(expDrops));
      check("rand_ovf", aOvf, (expDrops > 0));
      vldSeen = aVld;
      if (aVld) begin
        if (expQ.size() == 0) begin
          check("rand_extra_word", aWord, 32'hFFFFFFFF ^ aWord);
        end else begin
          e = expQ.pop_front();
          check("rand_word", aWord, e[31:0]);
          check("rand_first", aFirst, e[32]);
        end
      end
      aFull = ($urandom_range(0, 4) == 0);
      if (vldSeen && aFull) expDrops++;
      if (blockLeft == 0 && (cyc == 3 || $urandom_range(0, 119) == 0)) begin
`ifdef HDMI_PACKER_FLUSH_EN
        if (synced && q.size() > 0) begin
          mw = 0;
          for (int b = 0; b < q.size(); b++) mw[31-8*b -: 8] = q[b];
          expQ.push_back({1'b0, mw});
        end
`endif
        q.delete();
        synced = 1; armed = 1;
        vsHold = 3; blockLeft = 6;
      end
      if (vsHold > 0) begin aVs = 1; vsHold--; end else aVs = 0;
      if (blockLeft > 0) begin
        aEn = 0; blockLeft--;
      end else begin
        aEn = ($urandom_range(0, 3) != 0);
        aData = 24'($urandom());
        if (aEn && synced) begin
          q.push_back(aData[23:16]); q.push_back(aData[15:8]); q.push_back(aData[7:0]);
          while (q.size() >= 4) begin
            mw = {q[0], q[1], q[2], q[3]};
            repeat (4) void'(q.pop_front());
            expQ.push_back({armed, mw});
            armed = 0;
          end
        end
      end
      @(negedge clk);
    end
    aEn = 0; aVs = 0; aFull = 0;
    for (int k = 0; k < 3; k++) begin
      if (aVld) begin
        if (expQ.size() == 0) begin
          check("rand_tail_extra", aWord, 32'hFFFFFFFF ^ aWord);
        end else begin
          e = expQ.pop_front();
          check("rand_tail_word", aWord, e[31:0]);
        end
      end
      @(negedge clk);
    end
    check("rand_leftover", expQ.size(), 0);
    check("rand_drop_final", aDrop, 16'(expDrops));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
